// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: PC defaults, the PC step
// and the {pc, inst} entry buffered between memory and decode.
package if_prefetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the prefetch unit (master), instruction memory, redirect logic
// and decode (slave side is everything around the unit).
interface if_prefetch_unit_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_prefetch_unit_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (i_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch: credit-limited sequential fetch, in-order response capture
// into a small queue, and redirect handling that squashes in-flight responses.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    if_prefetch_unit_if.master bus
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(DEPTH);

    logic          r_started;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic [31:0]   w_target;
    logic          w_redirect;
    logic          w_req;
    logic          w_issue;
    logic          w_drop;
    logic          w_push;
    logic          w_inst_valid;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    assign w_redirect   = bus.redirect_valid;
    assign w_target     = word_align(bus.redirect_pc);
    // Queued plus in-flight words never exceed DEPTH, so a response always has room.
    assign w_inflight   = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_req        = r_started & ~w_redirect & (w_inflight < CREDIT_MAX);
    assign w_issue      = w_req & bus.imem_gnt;
    assign w_drop       = bus.imem_rvalid & (r_drop_cnt != '0);
    assign w_push       = bus.imem_rvalid & ~w_drop & ~w_redirect;
    assign w_inst_valid = (w_count != '0) & ~w_redirect;
    assign w_pop        = w_inst_valid & bus.inst_ready;
    assign w_push_data  = '{pc: r_resp_pc, inst: bus.imem_rdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_started     <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(bus.imem_rvalid);
            // Every word still in flight after this edge belongs to the old stream.
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= r_outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + PC_INC;
                if (w_push)  r_resp_pc  <= r_resp_pc + PC_INC;
                if (w_drop)  r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    if_prefetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst       = w_head.inst;
    assign bus.inst_pc    = w_head.pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: a memory model answers grants in order with
// variable latency, and every decoded word is checked against the expected PC stream.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_unit_if bus();

    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc = RPC;
    int          cyc = 0, lat = 1, last_due = 0;
    int          issues = 0, pops = 0;
    int          checks = 0, failures = 0;
    logic [31:0] last_pop_pc = '0;
    logic        s_req, s_valid, s_rvalid;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One clock of stimulus: drive inputs at negedge, then record what the next edge does.
    task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
        pend_t p;
        exp_t  e;
        @(negedge clk);
        bus.imem_gnt       = gnt;
        bus.inst_ready     = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        s_req = bus.imem_req; s_valid = bus.inst_valid;
        s_rvalid = bus.imem_rvalid; s_addr = bus.imem_addr;
        if (bus.imem_req && gnt) begin
            check("issue_addr", bus.imem_addr, model_pc);
            p.addr = bus.imem_addr;
            p.due  = (cyc + lat > last_due) ? cyc + lat : last_due;
            last_due = p.due;
            pend_q.push_back(p);
            e.pc = model_pc; e.inst = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc += 32'd4;
            issues++;
        end
        if (bus.imem_rvalid) void'(pend_q.pop_front());
        if (redir) begin
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic redirect_expect(input logic [31:0] tgt, input logic [31:0] want, input string nm);
        int p;
        cycle(1'b1, 1'b1, 1'b1, tgt);
        p = pops;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check({nm, "_addr"}, s_addr, want);
        for (int k = 0; k < 30 && pops == p; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check({nm, "_progress"}, 32'(pops > p), 32'd1);
        check({nm, "_first_pc"}, last_pop_pc, want);
    endtask

    // Monitor: whenever decode sees a valid head, it must be the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.inst_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL valid_unexpected actual_pc=%h required=no_valid", bus.inst_pc);
                end else if (bus.inst_ready) begin
                    e = exp_q.pop_front();
                    pops++;
                    last_pop_pc = bus.inst_pc;
                    check("pop_pc", bus.inst_pc, e.pc);
                    check("pop_inst", bus.inst, e.inst);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int p0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_addr", bus.imem_addr, RPC);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_gnt = 1'b1;
        #1;
        check("req_first_cycle", 32'(bus.imem_req), 32'd0);

        // Decode stalled: credits cap issue at DEPTH words.
        lat = 1;
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_issues", 32'(issues), 32'(DEPTH));
        check("stall_req", 32'(s_req), 32'd0);
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_head_pc", bus.inst_pc, 32'h0);
        check("stall_head_inst", bus.inst, mem_word(32'h0));

        // Streaming: one instruction per cycle once the pipeline is full.
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        p0 = pops;
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("stream_rate", 32'(pops - p0), 32'd12);

        lat = 3;
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        redirect_expect(32'h0000_0100, 32'h0000_0100, "redir_lat3");

        lat = 1;
        redirect_expect(32'h0000_0203, 32'h0000_0200, "redir_unaligned");

        // Redirect coinciding with a response and a would-be pop.
        lat = 2;
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("pre_redir_valid", 32'(s_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        check("redir_rvalid", 32'(s_rvalid), 32'd1);
        check("redir_valid_masked", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("post_redir_empty", 32'(s_valid), 32'd0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset with a partly full queue.
        lat = 1;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_reset_valid", 32'(s_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.imem_rvalid = 1'b0;
        exp_q.delete(); pend_q.delete();
        model_pc = RPC; last_due = 0;
        #1;
        check("async_rst_valid", 32'(bus.inst_valid), 32'd0);
        check("async_rst_req", 32'(bus.imem_req), 32'd0);
        check("async_rst_addr", bus.imem_addr, RPC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart_req_low", 32'(bus.imem_req), 32'd0);
        p0 = pops;
        for (int k = 0; k < 30 && pops == p0; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("restart_first_pc", last_pop_pc, RPC);

        // Randomized traffic, including redirects near the top of the address space.
        for (int n = 0; n < 1500; n++) begin
            bit          rd;
            logic [31:0] tgt;
            lat = $urandom_range(1, 4);
            rd  = ($urandom_range(0, 99) < 3);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), rd, tgt);
        end

        // Drain: every granted word of the current stream must reach decode.
        repeat (30) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
